// File: rtl/memstage_pkg.sv
// Shared constants for the memory-access stage: op codes, FSM states,
// register widths and small op-classification helpers.
package memstage_pkg;

    localparam int CPU_REG_WIDTH   = 32;
    localparam int CPU_REGNO_WIDTH = 5;

    localparam logic [3:0] MOP_NONE = 4'd0;
    localparam logic [3:0] MOP_LB   = 4'd1;
    localparam logic [3:0] MOP_LBU  = 4'd2;
    localparam logic [3:0] MOP_LH   = 4'd3;
    localparam logic [3:0] MOP_LHU  = 4'd4;
    localparam logic [3:0] MOP_LW   = 4'd5;
    localparam logic [3:0] MOP_SB   = 4'd6;
    localparam logic [3:0] MOP_SH   = 4'd7;
    localparam logic [3:0] MOP_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MOP_LB) && (op <= MOP_SW);
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return (op >= MOP_LB) && (op <= MOP_LW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op,
                                           input logic [1:0] off);
        logic half;
        logic word;
        half = (op == MOP_LH) || (op == MOP_LHU) || (op == MOP_SH);
        word = (op == MOP_LW) || (op == MOP_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memstage_fmt.sv
// Big-endian lane formatting: store byte enables / replicated write data,
// and load byte/half selection with sign or zero extension.
module memstage_fmt
    import memstage_pkg::*;
(
    input  logic [3:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [3:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_val
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store path: lane enables from size and offset, data replicated per lane
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        case (st_op)
            MOP_LB, MOP_LBU, MOP_SB: begin
                be    = 4'b1000 >> st_off;
                wdata = {4{st_data[7:0]}};
            end
            MOP_LH, MOP_LHU, MOP_SH: begin
                be    = st_off[1] ? 4'b0011 : 4'b1100;
                wdata = {2{st_data[15:0]}};
            end
            MOP_LW, MOP_SW: begin
                be    = 4'b1111;
                wdata = st_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

    // Load path: pick the addressed lane, then extend to register width
    always_comb begin
        ld_byte = 8'h0;
        ld_val  = 32'h0;
        case (ld_off)
            2'd0:    ld_byte = rdata[31:24];
            2'd1:    ld_byte = rdata[23:16];
            2'd2:    ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = ld_off[1] ? rdata[15:0] : rdata[31:16];
        case (ld_op)
            MOP_LB:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            MOP_LBU: ld_val = {24'h0, ld_byte};
            MOP_LH:  ld_val = {{16{ld_half[15]}}, ld_half};
            MOP_LHU: ld_val = {16'h0, ld_half};
            MOP_LW:  ld_val = rdata;
            default: ld_val = 32'h0;
        endcase
    end

endmodule

// File: rtl/memstage.sv
// Memory-access pipeline stage: passes ALU results through, runs one
// req/ack bus transfer per load/store. Option: MEMSTAGE_ALIGN_CHECK_EN.
module memstage
    import memstage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_exec_stall,
    input  logic                       i_fetch_stall,
    output logic                       o_mem_stall,
    input  logic [3:0]                 i_op,
    input  logic [CPU_REGNO_WIDTH-1:0] i_rd_no,
    input  logic [DATA_W-1:0]          i_rd_val,
    input  logic [DATA_W-1:0]          i_st_data,
    output logic [CPU_REGNO_WIDTH-1:0] o_rd_no,
    output logic [DATA_W-1:0]          o_rd_val,
    output logic [ADDR_W-1:0]          o_bus_addr,
    output logic                       o_bus_req,
    output logic                       o_bus_rnw,
    output logic [3:0]                 o_bus_be,
    output logic [DATA_W-1:0]          o_bus_wdata,
    input  logic                       i_bus_ack,
    input  logic [DATA_W-1:0]          i_bus_rdata
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    ,
    output logic                       o_addr_err
`endif
);

    state_t                     state;
    state_t                     state_next;
    logic [3:0]                 op_q;
    logic [1:0]                 off_q;
    logic [CPU_REGNO_WIDTH-1:0] rd_no_q;
    logic [DATA_W-1:0]          res_q;

    logic                       mem_op;
    logic                       ext_stall;
    logic                       core_stall;
    logic                       take_nop;
    logic                       take_mem;
    logic                       take_err;
    logic                       capture;
    logic                       retire;

    logic [3:0]                 st_be;
    logic [31:0]                st_wdata;
    logic [31:0]                ld_val;

    assign mem_op      = is_mem_op(i_op);
    assign ext_stall   = i_exec_stall | i_fetch_stall;
    assign o_mem_stall = ((state == ST_IDLE) && mem_op) || (state == ST_WAIT);
    assign core_stall  = ext_stall | o_mem_stall;

    memstage_fmt u_fmt (
        .st_op   (i_op),
        .st_off  (i_rd_val[1:0]),
        .st_data (i_st_data),
        .be      (st_be),
        .wdata   (st_wdata),
        .ld_op   (op_q),
        .ld_off  (off_q),
        .rdata   (i_bus_rdata),
        .ld_val  (ld_val)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle action strobes
    always_comb begin
        state_next = state;
        take_nop   = 1'b0;
        take_mem   = 1'b0;
        take_err   = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mem_op) begin
                    take_nop = !core_stall;
                end else if (!ext_stall) begin
`ifdef MEMSTAGE_ALIGN_CHECK_EN
                    if (is_misaligned(i_op, i_rd_val[1:0])) begin
                        take_err   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        take_mem   = 1'b1;
                        state_next = ST_WAIT;
                    end
`else
                    take_mem   = 1'b1;
                    state_next = ST_WAIT;
`endif
                end
            end
            ST_WAIT: begin
                if (i_bus_ack) begin
                    capture    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!ext_stall) begin
                    retire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus request, access bookkeeping and writeback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_no     <= '0;
            o_rd_val    <= '0;
            o_bus_addr  <= '0;
            o_bus_req   <= 1'b0;
            o_bus_rnw   <= 1'b0;
            o_bus_be    <= 4'b0000;
            o_bus_wdata <= '0;
            op_q        <= MOP_NONE;
            off_q       <= 2'b00;
            rd_no_q     <= '0;
            res_q       <= '0;
        end else begin
            if (take_nop) begin
                o_rd_no  <= i_rd_no;
                o_rd_val <= i_rd_val;
            end
            if (take_mem) begin
                o_bus_addr  <= {i_rd_val[ADDR_W-1:2], 2'b00};
                o_bus_rnw   <= is_load_op(i_op);
                o_bus_be    <= st_be;
                o_bus_wdata <= st_wdata;
                o_bus_req   <= 1'b1;
                op_q        <= i_op;
                off_q       <= i_rd_val[1:0];
                rd_no_q     <= is_load_op(i_op) ? i_rd_no : '0;
            end
            if (take_err) begin
                rd_no_q <= '0;
                res_q   <= '0;
            end
            if (capture) begin
                o_bus_req <= 1'b0;
                res_q     <= ld_val;
            end
            if (retire) begin
                o_rd_no  <= rd_no_q;
                o_rd_val <= res_q;
            end
        end
    end

`ifdef MEMSTAGE_ALIGN_CHECK_EN
    // Misalignment flag is a single-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_addr_err <= 1'b0;
        else     o_addr_err <= take_err;
    end
`endif

endmodule

// File: tb/tb_memstage.sv
// Directed self-checking bench for memstage.
module tb_memstage;
    import memstage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall;
    logic        i_fetch_stall;
    logic        o_mem_stall;
    logic [3:0]  i_op;
    logic [4:0]  i_rd_no;
    logic [31:0] i_rd_val;
    logic [31:0] i_st_data;
    logic [4:0]  o_rd_no;
    logic [31:0] o_rd_val;
    logic [31:0] o_bus_addr;
    logic        o_bus_req;
    logic        o_bus_rnw;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    logic        o_addr_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int stall_base;

    always #5 clk = ~clk;

    memstage dut (
        .clk           (clk),
        .rst           (rst),
        .i_exec_stall  (i_exec_stall),
        .i_fetch_stall (i_fetch_stall),
        .o_mem_stall   (o_mem_stall),
        .i_op          (i_op),
        .i_rd_no       (i_rd_no),
        .i_rd_val      (i_rd_val),
        .i_st_data     (i_st_data),
        .o_rd_no       (o_rd_no),
        .o_rd_val      (o_rd_val),
        .o_bus_addr    (o_bus_addr),
        .o_bus_req     (o_bus_req),
        .o_bus_rnw     (o_bus_rnw),
        .o_bus_be      (o_bus_be),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ack     (i_bus_ack),
        .i_bus_rdata   (i_bus_rdata)
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        ,
        .o_addr_err    (o_addr_err)
`endif
    );

    always @(negedge clk) begin
        if (o_mem_stall) stall_cnt <= stall_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [4:0] rd,
                          input logic [31:0] val);
        i_op     = op;
        i_rd_no  = rd;
        i_rd_val = val;
    endtask

    // One load with ack on the first WAIT cycle
    task automatic do_load(input string tag, input logic [3:0] op,
                           input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] be,
                           input logic [31:0] exp);
        set_op(op, rd, addr);
        #1;
        chk({tag, "_stall"}, o_mem_stall, 1'b1);
        tick();
        chk({tag, "_addr"}, o_bus_addr, {addr[31:2], 2'b00});
        chk({tag, "_be"}, o_bus_be, be);
        chk({tag, "_rnw"}, o_bus_rnw, 1'b1);
        i_bus_ack   = 1'b1;
        i_bus_rdata = rdata;
        tick();
        i_bus_ack = 1'b0;
        #1;
        chk({tag, "_req_clr"}, o_bus_req, 1'b0);
        tick();
        chk({tag, "_rd_no"}, o_rd_no, rd);
        chk({tag, "_rd_val"}, o_rd_val, exp);
        set_op(MOP_NONE, 5'd0, 32'h0);
    endtask

    initial begin
        rst           = 1'b1;
        i_exec_stall  = 1'b0;
        i_fetch_stall = 1'b0;
        i_bus_ack     = 1'b0;
        i_bus_rdata   = 32'h0;
        i_st_data     = 32'h0;
        set_op(MOP_NONE, 5'd0, 32'h0);
        tick();
        tick();
        chk("rst_rd_no", o_rd_no, 5'd0);
        chk("rst_rd_val", o_rd_val, 32'h0);
        chk("rst_req", o_bus_req, 1'b0);
        chk("rst_addr", o_bus_addr, 32'h0);
        chk("rst_stall", o_mem_stall, 1'b0);
        rst = 1'b0;
        tick();

        // Pass-through
        set_op(MOP_NONE, 5'd5, 32'h1234);
        #1;
        chk("nop_stall", o_mem_stall, 1'b0);
        tick();
        chk("nop_rd_no", o_rd_no, 5'd5);
        chk("nop_rd_val", o_rd_val, 32'h1234);
        chk("nop_req", o_bus_req, 1'b0);

        // Undefined op behaves as NONE
        set_op(4'hF, 5'd7, 32'h55);
        #1;
        chk("undef_stall", o_mem_stall, 1'b0);
        tick();
        chk("undef_rd_no", o_rd_no, 5'd7);
        chk("undef_rd_val", o_rd_val, 32'h55);
        chk("undef_req", o_bus_req, 1'b0);

        // LB 0x102, two wait cycles before ack
        stall_base = stall_cnt;
        set_op(MOP_LB, 5'd3, 32'h102);
        #1;
        chk("lb_stall0", o_mem_stall, 1'b1);
        tick();
        chk("lb_req", o_bus_req, 1'b1);
        chk("lb_addr", o_bus_addr, 32'h100);
        chk("lb_be", o_bus_be, 4'b0010);
        chk("lb_rnw", o_bus_rnw, 1'b1);
        tick();
        chk("lb_req_hold", o_bus_req, 1'b1);
        tick();
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h11228344;
        tick();
        i_bus_ack = 1'b0;
        #1;
        chk("lb_done_stall", o_mem_stall, 1'b0);
        chk("lb_done_req", o_bus_req, 1'b0);
        chk("lb_done_rd_old", o_rd_no, 5'd7);
        tick();
        chk("lb_rd_no", o_rd_no, 5'd3);
        chk("lb_rd_val", o_rd_val, 32'hFFFFFF83);
        chk("lb_stall_cycles", stall_cnt - stall_base, 4);
        set_op(MOP_NONE, 5'd4, 32'h44);
        tick();

        // SH 0x202
        set_op(MOP_SH, 5'd9, 32'h202);
        i_st_data = 32'hDEADBEEF;
        tick();
        chk("sh_req", o_bus_req, 1'b1);
        chk("sh_addr", o_bus_addr, 32'h200);
        chk("sh_be", o_bus_be, 4'b0011);
        chk("sh_wdata", o_bus_wdata, 32'hBEEFBEEF);
        chk("sh_rnw", o_bus_rnw, 1'b0);
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        chk("sh_pre_rd_no", o_rd_no, 5'd4);
        tick();
        chk("sh_rd_no", o_rd_no, 5'd0);
        chk("sh_rd_val", o_rd_val, 32'h0);

        // SB 0x301: second lane, byte replicated
        set_op(MOP_SB, 5'd2, 32'h301);
        i_st_data = 32'h000000A5;
        tick();
        chk("sb_be", o_bus_be, 4'b0100);
        chk("sb_wdata", o_bus_wdata, 32'hA5A5A5A5);
        i_bus_ack = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        tick();
        set_op(MOP_NONE, 5'd1, 32'h11);
        tick();

        // LW completing under a 3-cycle execute stall
        set_op(MOP_LW, 5'd10, 32'h300);
        tick();
        chk("lw_be", o_bus_be, 4'b1111);
        i_bus_ack    = 1'b1;
        i_bus_rdata  = 32'hCAFEF00D;
        i_exec_stall = 1'b1;
        tick();
        i_bus_ack = 1'b0;
        chk("lw_st1_rd_no", o_rd_no, 5'd1);
        tick();
        chk("lw_st2_rd_val", o_rd_val, 32'h11);
        chk("lw_st2_req", o_bus_req, 1'b0);
        tick();
        i_exec_stall = 1'b0;
        chk("lw_st3_rd_no", o_rd_no, 5'd1);
        chk("lw_st3_req", o_bus_req, 1'b0);
        tick();
        chk("lw_rd_no", o_rd_no, 5'd10);
        chk("lw_rd_val", o_rd_val, 32'hCAFEF00D);
        chk("lw_no_req", o_bus_req, 1'b0);
        set_op(MOP_NONE, 5'd0, 32'h0);
        tick();

        // Lane select and extension variants
        do_load("lbu", MOP_LBU, 5'd11, 32'h103, 32'h112233F4, 4'b0001,
                32'h000000F4);
        do_load("lh", MOP_LH, 5'd12, 32'h402, 32'h1234ABCD, 4'b0011,
                32'hFFFFABCD);
        do_load("lhu", MOP_LHU, 5'd13, 32'h400, 32'h8001ABCD, 4'b1100,
                32'h00008001);

`ifndef MEMSTAGE_ALIGN_CHECK_EN
        // Misaligned word: low address bits ignored
        do_load("lw_unal", MOP_LW, 5'd14, 32'h103, 32'h89ABCDEF, 4'b1111,
                32'h89ABCDEF);
`else
        set_op(MOP_NONE, 5'd7, 32'h77);
        tick();
        set_op(MOP_LW, 5'd6, 32'h101);
        #1;
        chk("aerr_stall", o_mem_stall, 1'b1);
        tick();
        chk("aerr_req", o_bus_req, 1'b0);
        chk("aerr_pulse", o_addr_err, 1'b1);
        tick();
        chk("aerr_clear", o_addr_err, 1'b0);
        chk("aerr_rd_no", o_rd_no, 5'd0);
        set_op(MOP_NONE, 5'd0, 32'h0);
        tick();
`endif

        // Reset in the middle of WAIT
        set_op(MOP_NONE, 5'd8, 32'h88);
        tick();
        set_op(MOP_LW, 5'd9, 32'h500);
        tick();
        chk("mrst_req_on", o_bus_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_req_drop", o_bus_req, 1'b0);
        set_op(MOP_NONE, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_rd_no", o_rd_no, 5'd0);
        chk("mrst_rd_val", o_rd_val, 32'h0);
        chk("mrst_addr", o_bus_addr, 32'h0);
        chk("mrst_be", o_bus_be, 4'b0000);
        chk("mrst_stall", o_mem_stall, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
